// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory bus between instruction fetch and load/store; MEM wins ties.
// Define MEMARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT consecutive IF losses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;
  state_t state;

  // A requester whose ack is high this cycle is still holding the finished request.
  logic if_cand, mem_cand, grant_mem;
  assign if_cand  = if_req_i  & ~if_ack_o;
  assign mem_cand = mem_req_i & ~mem_ack_o;

  assign stall_if_o  = if_req_i  & ~if_ack_o;
  assign stall_mem_o = mem_req_i & ~mem_ack_o;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  assign starved   = if_cand && (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign grant_mem = mem_cand & ~starved;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_mem && if_cand && (starve_cnt < CNT_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
      else if (!grant_mem && if_cand)
        starve_cnt <= '0;
    end
  end
`else
  assign grant_mem = mem_cand;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'h0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state       <= GNT_MEM;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_sel_o   <= mem_sel_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
          end else if (if_cand) begin
            state       <= GNT_IF;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'hF;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
          end
        end
        GNT_IF: begin
          if (bus_ack_i) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            if_data_o <= bus_rdata_i;
            if_ack_o  <= 1'b1;
          end
        end
        GNT_MEM: begin
          if (bus_ack_i) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            mem_rdata_o <= bus_rdata_i;
            mem_ack_o   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change on negedge, outputs sampled on negedge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i, mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i;
  logic        stall_if_o, stall_mem_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  task automatic test_reset;
    rst = 1'b1; if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; bus_rdata_i = 32'hFFFF_FFFF; bus_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus_req_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctl: got %b want 00000000", {bus_req_o, bus_we_o, bus_sel_o, if_ack_o, mem_ack_o}); end
    n_cmp++; if ({bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o} !== 128'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o}); end
    rst = 1'b0; bus_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus_req_o, if_ack_o, mem_ack_o, stall_if_o, stall_mem_o} !== 5'b0) begin
      n_err++; $display("FAIL idle_ack_ignored: got %b want 00000", {bus_req_o, if_ack_o, mem_ack_o, stall_if_o, stall_mem_o}); end
  endtask

  task automatic test_fetch;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(negedge clk);
    n_cmp++; if ({bus_req_o, bus_we_o, bus_sel_o, stall_if_o} !== 7'b1011111) begin
      n_err++; $display("FAIL fetch_ctl: got %b want 1011111", {bus_req_o, bus_we_o, bus_sel_o, stall_if_o}); end
    n_cmp++; if (bus_addr_o !== 32'h100) begin
      n_err++; $display("FAIL fetch_addr: got %h want 00000100", bus_addr_o); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({bus_req_o, if_ack_o} !== 2'b10) begin
      n_err++; $display("FAIL fetch_wait: got %b want 10", {bus_req_o, if_ack_o}); end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0050_0093;
    @(negedge clk);
    n_cmp++; if ({if_ack_o, bus_req_o, stall_if_o} !== 3'b100 || if_data_o !== 32'h0050_0093) begin
      n_err++; $display("FAIL fetch_ack: got %b/%h want 100/00500093", {if_ack_o, bus_req_o, stall_if_o}, if_data_o); end
    if_req_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'hAAAA_AAAA;
    @(negedge clk);
    n_cmp++; if (if_ack_o !== 1'b0 || if_data_o !== 32'h0050_0093) begin
      n_err++; $display("FAIL fetch_pulse_hold: got %b/%h want 0/00500093", if_ack_o, if_data_o); end
  endtask

  task automatic test_simultaneous;
    if_req_i = 1; if_addr_i = 32'h104; mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF;
    mem_addr_i = 32'h2000; bus_ack_i = 1; bus_rdata_i = 32'h1111_1111;
    @(negedge clk);
    n_cmp++; if (bus_addr_o !== 32'h2000 || {bus_req_o, stall_if_o, stall_mem_o} !== 3'b111) begin
      n_err++; $display("FAIL sim_mem_first: got %h/%b want 00002000/111", bus_addr_o, {bus_req_o, stall_if_o, stall_mem_o}); end
    @(negedge clk);
    n_cmp++; if ({mem_ack_o, stall_mem_o, stall_if_o, bus_req_o} !== 4'b1010 || mem_rdata_o !== 32'h1111_1111) begin
      n_err++; $display("FAIL sim_mem_ack: got %b/%h want 1010/11111111", {mem_ack_o, stall_mem_o, stall_if_o, bus_req_o}, mem_rdata_o); end
    bus_rdata_i = 32'h2222_2222;
    @(negedge clk);
    mem_req_i = 0;
    n_cmp++; if (bus_addr_o !== 32'h104 || {bus_req_o, bus_sel_o, mem_ack_o, stall_if_o} !== 7'b1111101) begin
      n_err++; $display("FAIL sim_if_second: got %h/%b want 00000104/1111101", bus_addr_o, {bus_req_o, bus_sel_o, mem_ack_o, stall_if_o}); end
    @(negedge clk);
    n_cmp++; if ({if_ack_o, stall_if_o} !== 2'b10 || if_data_o !== 32'h2222_2222) begin
      n_err++; $display("FAIL sim_if_ack: got %b/%h want 10/22222222", {if_ack_o, stall_if_o}, if_data_o); end
    if_req_i = 0; bus_ack_i = 0;
    @(negedge clk);
  endtask

  task automatic test_store;
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011; mem_addr_i = 32'h2004; mem_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'b110011 || bus_addr_o !== 32'h2004 || bus_wdata_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL store_bus: got %b/%h/%h want 110011/00002004/deadbeef", {bus_req_o, bus_we_o, bus_sel_o}, bus_addr_o, bus_wdata_o); end
    bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    n_cmp++; if ({mem_ack_o, bus_req_o, if_ack_o} !== 3'b100 || mem_rdata_o !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL store_ack: got %b/%h want 100/0badf00d", {mem_ack_o, bus_req_o, if_ack_o}, mem_rdata_o); end
    mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0;
    @(negedge clk);
    n_cmp++; if (mem_ack_o !== 1'b0) begin
      n_err++; $display("FAIL store_pulse: got %b want 0", mem_ack_o); end
  endtask

  task automatic test_input_change;
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h2008; mem_wdata_i = 32'h5555_5555;
    @(negedge clk);
    mem_addr_i = 32'h4000; mem_wdata_i = 32'h6666_6666; mem_sel_i = 4'h1; mem_we_i = 1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus_addr_o !== 32'h2008 || bus_wdata_o !== 32'h5555_5555 || {bus_req_o, bus_we_o, bus_sel_o} !== 6'b101111) begin
      n_err++; $display("FAIL latched_inputs: got %h/%h/%b want 00002008/55555555/101111", bus_addr_o, bus_wdata_o, {bus_req_o, bus_we_o, bus_sel_o}); end
    bus_ack_i = 1; bus_rdata_i = 32'h7777_7777;
    @(negedge clk);
    n_cmp++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h7777_7777) begin
      n_err++; $display("FAIL latched_ack: got %b/%h want 1/77777777", mem_ack_o, mem_rdata_o); end
    mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    mem_req_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h2010;
    @(negedge clk);
    n_cmp++; if (bus_req_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_req: got %b want 1", bus_req_o); end
    rst = 1; mem_req_i = 0;
    @(negedge clk);
    n_cmp++; if ({bus_req_o, mem_ack_o} !== 2'b00 || bus_addr_o !== 32'h0) begin
      n_err++; $display("FAIL rstmid_abort: got %b/%h want 00/00000000", {bus_req_o, mem_ack_o}, bus_addr_o); end
    rst = 0; bus_ack_i = 1; bus_rdata_i = 32'h0000_0013;
    @(negedge clk);
    n_cmp++; if ({bus_req_o, mem_ack_o, if_ack_o} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_noack: got %b want 000", {bus_req_o, mem_ack_o, if_ack_o}); end
    bus_ack_i = 0; if_req_i = 1; if_addr_i = 32'h200;
    @(negedge clk);
    n_cmp++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h200) begin
      n_err++; $display("FAIL rstmid_fetch_req: got %b/%h want 1/00000200", bus_req_o, bus_addr_o); end
    bus_ack_i = 1;
    @(negedge clk);
    n_cmp++; if (if_ack_o !== 1'b1 || if_data_o !== 32'h0000_0013) begin
      n_err++; $display("FAIL rstmid_fetch_ack: got %b/%h want 1/00000013", if_ack_o, if_data_o); end
    if_req_i = 0; bus_ack_i = 0;
    @(negedge clk);
  endtask

  // Five contended arbitrations, each starting from a quiet IDLE; requesters withdraw after each MEM ack.
  task automatic test_starvation;
    logic exp_if;
    for (int r = 1; r <= 5; r++) begin
`ifdef MEMARB_STARVE_GUARD_EN
      exp_if = (r == 5);
`else
      exp_if = 1'b0;
`endif
      mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h3000 + 32'(4 * r);
      if_req_i = 1; if_addr_i = 32'h400; bus_ack_i = 1; bus_rdata_i = 32'h100 + 32'(r);
      @(negedge clk);
      n_cmp++; if (bus_addr_o !== (exp_if ? 32'h400 : 32'h3000 + 32'(4 * r))) begin
        n_err++; $display("FAIL starve_grant_r%0d: got %h want %h", r, bus_addr_o, exp_if ? 32'h400 : 32'h3000 + 32'(4 * r)); end
      @(negedge clk);
      n_cmp++; if ({if_ack_o, mem_ack_o} !== (exp_if ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL starve_ack_r%0d: got %b want %b", r, {if_ack_o, mem_ack_o}, exp_if ? 2'b10 : 2'b01); end
      mem_req_i = 0; if_req_i = 0; bus_ack_i = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_simultaneous;
    test_store;
    test_input_change;
    test_reset_mid;
    test_starvation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
